// File: rtl/bus_register.sv
// Edge-triggered datapath storage register.
// Ports: clock, clear (sync, active-high), enable, BUS_MUX_OUT in, BUS_MUX_IN out.
module bus_register #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT      = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] BUS_MUX_OUT,
  output logic [DATA_WIDTH-1:0] BUS_MUX_IN
);

  // Declaration initializer gives the INIT power-up value.
  logic [DATA_WIDTH-1:0] q = INIT;

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= INIT;
    end else if (enable) begin
      q <= BUS_MUX_OUT;
    end
  end

  assign BUS_MUX_IN = q;

endmodule

// File: tb/tb_bus_register.sv
// Self-checking bench for bus_register.
// Two instances: default INIT and INIT = 32'hDEAD_BEEF.
module tb_bus_register;

  localparam logic [31:0] INIT_B = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_a, enable_a;
  logic [31:0] d_a, q_a;
  logic        clear_b, enable_b;
  logic [31:0] d_b, q_b;

  bus_register #(
    .DATA_WIDTH(32)
  ) u_a (
    .clock      (clock),
    .clear      (clear_a),
    .enable     (enable_a),
    .BUS_MUX_OUT(d_a),
    .BUS_MUX_IN (q_a)
  );

  bus_register #(
    .DATA_WIDTH(32),
    .INIT      (INIT_B)
  ) u_b (
    .clock      (clock),
    .clear      (clear_b),
    .enable     (enable_b),
    .BUS_MUX_OUT(d_b),
    .BUS_MUX_IN (q_b)
  );

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = INIT_B;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive both instances, confirm nothing
  // reaches the output before the edge, then check after it.
  task automatic step(input string tag,
                      input logic ca, input logic ea, input logic [31:0] da,
                      input logic cb, input logic eb, input logic [31:0] db);
    clear_a  = ca;
    enable_a = ea;
    d_a      = da;
    clear_b  = cb;
    enable_b = eb;
    d_b      = db;
    #1;
    check({tag, "_pre_a"}, q_a, m_a);
    check({tag, "_pre_b"}, q_b, m_b);
    if (ca)      m_a = 32'h0;
    else if (ea) m_a = da;
    if (cb)      m_b = INIT_B;
    else if (eb) m_b = db;
    @(posedge clock);
    #1;
    check({tag, "_a"}, q_a, m_a);
    check({tag, "_b"}, q_b, m_b);
    @(negedge clock);
  endtask

  initial begin
    clear_a  = 1'b0;
    enable_a = 1'b0;
    d_a      = 32'h0;
    clear_b  = 1'b0;
    enable_b = 1'b0;
    d_b      = 32'h0;
    #1;
    check("powerup_a", q_a, 32'h0);
    check("powerup_b", q_b, INIT_B);
    @(negedge clock);
    check("hold_first_b", q_b, INIT_B);

    step("load10",  0, 1, 32'd10,       0, 0, 32'h1234);
    step("load20",  0, 1, 32'd20,       0, 0, 32'h5678);
    step("hold30",  0, 0, 32'd30,       0, 0, 32'h9abc);
    step("clear",   1, 0, 32'd30,       0, 0, 32'h0);
    step("clrprio", 1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0);
    step("resume",  0, 1, 32'hFFFF_FFFF, 0, 1, 32'd5);
    step("clr_b",   0, 0, 32'h0,        1, 0, 32'h0);
    step("clr_hold", 1, 0, 32'h0,       1, 1, 32'h7777);
    step("clr_rel", 0, 1, 32'hA5A5_5A5A, 0, 1, 32'h1111_2222);

    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom,
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
